ncl_sync_tx: RTL

Clocked-to-NCL transmitter: accepts single-rail words on a valid/ready interface in the `clk` domain and injects them as dual-rail NCL wavefronts (DATA, then NULL) into an asynchronous NCL pipeline. Flow control comes from the downstream completion signal `ZCOMP`: low requests DATA, high requests NULL, matching the `THnot`-enabled buffer stages. This block is the source end of a ring or pipeline, driving stage 0 from synchronous logic.

---
 rtl/ncl_pkg.sv | 24 ++
 rtl/ncl_sync.sv | 25 ++
 rtl/ncl_sync_tx.sv | 96 +++++++++
 3 files changed

// File: rtl/ncl_pkg.sv
// Shared NCL definitions: FSM states, rail indices and the dual-rail digit encoder.
// Imported by the clocked-to-NCL transmitter and the matching receiver.
package ncl_pkg;

  typedef enum logic [0:0] {
    S_NULL = 1'b0,
    S_DATA = 1'b1
  } tx_state_e;

  localparam int RAIL0 = 0;
  localparam int RAIL1 = 1;

  localparam logic [1:0] NULL_DIGIT = 2'b00;

  // A set bit raises rail 1, a clear bit raises rail 0; never both.
  function automatic logic [1:0] dr_encode(input logic b);
    logic [1:0] digit;
    digit        = NULL_DIGIT;
    digit[RAIL1] = b;
    digit[RAIL0] = ~b;
    return digit;
  endfunction

endpackage

// File: rtl/ncl_sync.sv
// Multi-flop synchronizer for an asynchronous level, with a selectable reset value.
// Shared by the NCL transmitter and receiver for their completion inputs.
module ncl_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic init,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (init) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_sync_tx.sv
// Clocked-to-NCL transmitter: takes valid/ready words and drives them into an NCL
// pipeline as DATA then NULL wavefronts, paced by the synchronized completion ZCOMP.
module ncl_sync_tx
  import ncl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               init,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] Z,
  input  logic               ZCOMP,
  output logic               stall,
  output logic [15:0]        tx_count
);

  localparam int unsigned   TmoW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  tx_state_e          state_q;
  logic [2*WIDTH-1:0] z_q;
  logic [15:0]        tx_count_q;
  logic               stall_q;
  logic [TmoW-1:0]    tmo_q;
  logic               zc_s;
  logic               accept;
  logic [2*WIDTH-1:0] z_data;

  // Reset to 1 so nothing is offered until downstream has visibly requested DATA.
  ncl_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_zcomp_sync (
    .clk (clk),
    .init(init),
    .d   (ZCOMP),
    .q   (zc_s)
  );

  assign in_ready = (state_q == S_NULL) && !zc_s;
  assign accept   = in_valid && in_ready;

  always_comb begin
    z_data = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      z_data[2*i +: 2] = dr_encode(in_data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= S_NULL;
      z_q        <= {WIDTH{NULL_DIGIT}};
      tx_count_q <= 16'd0;
      stall_q    <= 1'b0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        S_NULL: begin
          if (accept) begin
            z_q     <= z_data;
            tmo_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (zc_s) begin
            z_q        <= {WIDTH{NULL_DIGIT}};
            tx_count_q <= tx_count_q + 16'd1;
            state_q    <= S_NULL;
          end else if (tmo_q != TmoMax) begin
            // Timeout only flags; the wavefront stays on Z until completion arrives.
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == TmoLast) begin
              stall_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_NULL;
          z_q     <= {WIDTH{NULL_DIGIT}};
        end
      endcase
    end
  end

  assign Z        = z_q;
  assign stall    = stall_q;
  assign tx_count = tx_count_q;

endmodule
